// File: rtl/rdq_fifo4x32.sv
// rdq_fifo4x32: four-entry first-word-fall-through queue built from enabled registers.
// Occupancy is tracked in a registered count, and full and empty are decoded from that count.
module rdq_fifo4x32 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       r,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  output logic                       o_full,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_ovf,
  output logic                       o_unf
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_ovf, r_unf;
  logic             w_push, w_pop;
  logic [DEPTH-1:0] w_we;
  assign o_full    = r_count == (AW+1)'(DEPTH);
  assign o_empty   = r_count == '0;
  assign o_count   = r_count;
  assign o_ovf     = r_ovf;
  assign o_unf     = r_unf;
  assign o_rd_data = r_mem[r_rd_ptr];
  // A push into a full queue is allowed when the head leaves in the same cycle.
  assign w_push = i_wr_en & (~o_full | i_rd_en);
  assign w_pop  = i_rd_en & ~o_empty;
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign w_we[i] = w_push & (r_wr_ptr == AW'(i));
    always_ff @(posedge clk)
      if (w_we[i]) r_mem[i] <= i_wr_data;
  end
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (i_wr_en & o_full & ~i_rd_en) r_ovf <= 1'b1;
      if (i_rd_en & o_empty) r_unf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rdq_fifo4x32.sv
// tb_rdq_fifo4x32: directed stimulus feeds a scoreboard of expected words.
// A negedge monitor checks every accepted pop, and status outputs are checked against a small model.
module tb_rdq_fifo4x32;
  logic        clk = 0;
  logic        r = 0;
  logic        wr_en = 0, rd_en = 0;
  logic [31:0] wr_data = '0;
  logic        full, empty, ovf, unf;
  logic [31:0] rd_data;
  logic [2:0]  count;
  int          checks = 0, errors = 0;
  logic [31:0] sb[$];
  int          m_count = 0;
  logic        m_ovf = 0, m_unf = 0;

  rdq_fifo4x32 dut (
    .clk(clk), .r(r), .i_wr_en(wr_en), .i_wr_data(wr_data), .o_full(full),
    .i_rd_en(rd_en), .o_rd_data(rd_data), .o_empty(empty), .o_count(count),
    .o_ovf(ovf), .o_unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_status(input string name);
    chk({name, ".count"}, 32'(count), 32'(m_count));
    chk({name, ".empty"}, 32'(empty), 32'(m_count == 0));
    chk({name, ".full"},  32'(full),  32'(m_count == 4));
    chk({name, ".ovf"},   32'(ovf),   32'(m_ovf));
    chk({name, ".unf"},   32'(unf),   32'(m_unf));
  endtask

  // Called just after a rising edge; applies one cycle of inputs and returns just after the next edge.
  task automatic drive(input logic we, input logic [31:0] wd, input logic re);
    logic push, pop;
    wr_en = we; wr_data = wd; rd_en = re;
    push = we & ((m_count < 4) | re);
    pop  = re & (m_count != 0);
    if (push) sb.push_back(wd);
    if (we & (m_count == 4) & ~re) m_ovf = 1;
    if (re & (m_count == 0)) m_unf = 1;
    m_count = m_count + int'(push) - int'(pop);
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0;
  endtask

  task automatic pop_n(input int n);
    for (int k = 0; k < n; k++) drive(0, '0, 1);
  endtask

  task automatic do_reset();
    r = 0;
    #2;
    sb.delete();
    m_count = 0; m_ovf = 0; m_unf = 0;
    r = 1;
  endtask

  always @(negedge clk) begin
    if (r && rd_en && !empty) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_unexpected: got %h expected no pop", rd_data);
      end else chk("pop_data", rd_data, sb.pop_front());
    end
  end

  initial begin
    #3 r = 0;
    @(posedge clk); #1;
    r = 1;
    for (int k = 0; k < 3; k++) drive(0, '0, 0);
    chk_status("reset_idle");
    for (int k = 1; k <= 4; k++) drive(1, 32'hA000_0000 + k, 0);
    chk_status("fill4");
    pop_n(4);
    chk_status("drain4");
    for (int k = 0; k < 4; k++) drive(1, 32'h1000 + k, 0);
    drive(1, 32'h0000_DEAD, 0);
    chk_status("overflow");
    chk("ovf_head", rd_data, 32'h1000);
    pop_n(4);
    do_reset();
    for (int k = 0; k < 4; k++) drive(1, 32'h2000 + k, 0);
    drive(1, 32'h0000_BEEF, 1);
    chk_status("full_push_pop");
    chk("full_pp_head", rd_data, 32'h2001);
    pop_n(4);
    chk_status("after_beef");
    drive(0, '0, 1);
    chk_status("underflow");
    drive(1, 32'h55, 1);
    chk_status("empty_push_pop");
    chk("fwft_55", rd_data, 32'h55);
    pop_n(1);
    drive(1, 32'h200, 0);
    drive(1, 32'h201, 0);
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'h100 + k, 1);
      chk(("wrap_count"), 32'(count), 32'd2);
    end
    chk_status("wrap_end");
    pop_n(2);
    for (int k = 0; k < 3; k++) drive(1, 32'h300 + k, 0);
    chk_status("pre_async");
    r = 0;
    #2;
    chk("async_count", 32'(count), 32'd0);
    chk("async_empty", 32'(empty), 32'd1);
    sb.delete();
    m_count = 0; m_ovf = 0; m_unf = 0;
    r = 1;
    chk_status("post_release");
    drive(1, 32'h77, 0);
    chk("post_rst_77", rd_data, 32'h77);
    chk_status("post_rst_push");
    pop_n(1);
    drive(0, '0, 0);
    chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
